// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR controller and its settle timer.
package sar_pkg;

    localparam int unsigned SAR_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        SAR_IDLE   = 2'd0,
        SAR_SETTLE = 2'd1,
        SAR_SAMPLE = 2'd2,
        SAR_DONE   = 2'd3
    } sar_state_e;

    // Settle counter width: clog2(SETTLE_CYCLES), never narrower than one bit.
    function automatic int unsigned sar_cnt_width(input int unsigned settle_cycles);
        return (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
    endfunction

endpackage

// File: rtl/sar_settle_timer.sv
// Settle-time counter: cleared by load, advanced by count, flags the final settle cycle.
module sar_settle_timer
    import sar_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic count_i,
    output logic expire_c_o
);

    localparam int unsigned CNT_W = sar_cnt_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expire_c_o = count_i && (count_q == LAST_CNT);

    always_comb begin
        count_d = count_q;
        if (load_i || expire_c_o) begin
            count_d = '0;
        end else if (count_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sar_controller_8_bit.sv
// MSB-first successive-approximation controller driving a magnitude comparator's B input.
// Optional macro SAR_EARLY_EXIT_EN: finish as soon as the comparator reports equality.
module sar_controller_8_bit
    import sar_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = SAR_DATA_WIDTH,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                  Clock_In,
    input  logic                  Reset_In,
    input  logic                  Start_In,
    input  logic                  A_Greater_Than_B_In,
    input  logic                  A_Equal_To_B_In,
    output logic [DATA_WIDTH-1:0] Trial_Data_Out,
    output logic [DATA_WIDTH-1:0] Result_Out,
    output logic                  Busy_Out,
    output logic                  Done_Out
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0]      IDX_MSB = IDX_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);

    sar_state_e            state_q,  state_d;
    logic [DATA_WIDTH-1:0] work_q,   work_d;
    logic [DATA_WIDTH-1:0] trial_q,  trial_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;

    logic                  keep_c;
    logic                  early_c;
    logic [DATA_WIDTH-1:0] work_kept_c;
    logic                  timer_load_c;
    logic                  timer_count_c;
    logic                  timer_expire_c;

    sar_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk_i     (Clock_In),
        .rst_i     (Reset_In),
        .load_i    (timer_load_c),
        .count_i   (timer_count_c),
        .expire_c_o(timer_expire_c)
    );

    // Illegal both-flags-high case falls out as keep=1.
    assign keep_c = A_Greater_Than_B_In | A_Equal_To_B_In;

`ifdef SAR_EARLY_EXIT_EN
    assign early_c = A_Equal_To_B_In;
`else
    assign early_c = 1'b0;
`endif

    always_comb begin
        work_kept_c         = work_q;
        work_kept_c[idx_q]  = keep_c;
    end

    always_comb begin
        state_d       = state_q;
        work_d        = work_q;
        trial_d       = trial_q;
        result_d      = result_q;
        idx_d         = idx_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        timer_load_c  = 1'b0;
        timer_count_c = 1'b0;

        case (state_q)
            SAR_IDLE, SAR_DONE: begin
                state_d = SAR_IDLE;
                busy_d  = 1'b0;
                if (Start_In) begin
                    state_d      = SAR_SETTLE;
                    busy_d       = 1'b1;
                    work_d       = '0;
                    trial_d      = ONE << IDX_MSB;
                    idx_d        = IDX_MSB;
                    timer_load_c = 1'b1;
                end
            end
            SAR_SETTLE: begin
                timer_count_c = 1'b1;
                if (timer_expire_c) begin
                    state_d = SAR_SAMPLE;
                end
            end
            SAR_SAMPLE: begin
                if (early_c) begin
                    // Exact match: the current trial already is the answer.
                    work_d   = trial_q;
                    result_d = trial_q;
                    state_d  = SAR_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else if (idx_q == '0) begin
                    work_d   = work_kept_c;
                    result_d = work_kept_c;
                    trial_d  = work_kept_c;
                    state_d  = SAR_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    work_d       = work_kept_c;
                    idx_d        = idx_q - IDX_W'(1);
                    trial_d      = work_kept_c | (ONE << (idx_q - IDX_W'(1)));
                    timer_load_c = 1'b1;
                    state_d      = SAR_SETTLE;
                end
            end
            default: begin
                state_d = SAR_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state_q  <= SAR_IDLE;
            work_q   <= '0;
            trial_q  <= '0;
            result_q <= '0;
            idx_q    <= IDX_MSB;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Trial_Data_Out = trial_q;
    assign Result_Out     = result_q;
    assign Busy_Out       = busy_q;
    assign Done_Out       = done_q;

endmodule

// File: tb/tb_sar_controller_8_bit.sv
// Directed bench: two controllers (settle 1 and settle 3) each closed around a comparator model.
module tb_sar_controller_8_bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a_val;

    logic [7:0] f_trial, f_result, s_trial, s_result;
    logic       f_busy, f_done, s_busy, s_done;
    logic       f_gt, f_eq, s_gt, s_eq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] trial_log [16];
    int         trial_cnt;

`ifdef SAR_EARLY_EXIT_EN
    localparam int LAT_3C   = 12;
    localparam int LAT_SLOW = 4;
`else
    localparam int LAT_3C   = 16;
    localparam int LAT_SLOW = 32;
`endif

    localparam logic [7:0] A5_SEQ [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    always #5 clk = ~clk;

    always_comb begin
        f_gt = a_val > f_trial;
        f_eq = a_val == f_trial;
        s_gt = a_val > s_trial;
        s_eq = a_val == s_trial;
    end

    sar_controller_8_bit dut_fast (
        .Clock_In           (clk),
        .Reset_In           (rst),
        .Start_In           (start),
        .A_Greater_Than_B_In(f_gt),
        .A_Equal_To_B_In    (f_eq),
        .Trial_Data_Out     (f_trial),
        .Result_Out         (f_result),
        .Busy_Out           (f_busy),
        .Done_Out           (f_done)
    );

    sar_controller_8_bit #(.SETTLE_CYCLES(3)) dut_slow (
        .Clock_In           (clk),
        .Reset_In           (rst),
        .Start_In           (start),
        .A_Greater_Than_B_In(s_gt),
        .A_Equal_To_B_In    (s_eq),
        .Trial_Data_Out     (s_trial),
        .Result_Out         (s_result),
        .Busy_Out           (s_busy),
        .Done_Out           (s_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called right after the accepting edge; returns edges until Done and busy samples before it.
    task automatic wait_done(input bit slow, input bit hold, output int lat, output int busy_n);
        lat       = -1;
        busy_n    = (slow ? s_busy : f_busy) ? 1 : 0;
        trial_log[0] = f_trial;
        trial_cnt = 1;
        for (int i = 1; i <= 200; i++) begin
            if (hold) start = 1'b1;
            tick();
            if (!slow && f_trial !== trial_log[trial_cnt-1] && trial_cnt < 16) begin
                trial_log[trial_cnt] = f_trial;
                trial_cnt++;
            end
            if (slow ? s_done : f_done) begin
                lat = i;
                break;
            end
            if (slow ? s_busy : f_busy) busy_n++;
        end
        if (hold) start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a_val = 8'h00;
        tick(); tick();
        n_checks++;
        if ({f_trial, f_result, f_busy, f_done} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_fast: got trial=%h result=%h busy=%b done=%b, need all 0", f_trial, f_result, f_busy, f_done);
        end
        n_checks++;
        if ({s_trial, s_result, s_busy, s_done} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_slow: got trial=%h result=%h busy=%b done=%b, need all 0", s_trial, s_result, s_busy, s_done);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat, busy_n;
        a_val = 8'hA5;
        start_pulse();
        wait_done(1'b0, 1'b0, lat, busy_n);
        n_checks++;
        if (lat !== 16) begin n_fail++; $display("FAIL a5_latency: got %0d, need 16", lat); end
        n_checks++;
        if (busy_n !== 16) begin n_fail++; $display("FAIL a5_busy_cycles: got %0d, need 16", busy_n); end
        n_checks++;
        if (f_result !== 8'hA5 || f_busy !== 1'b0) begin
            n_fail++; $display("FAIL a5_result: got %h busy=%b, need a5 busy=0", f_result, f_busy);
        end
        n_checks++;
        if (trial_cnt < 8) begin
            n_fail++; $display("FAIL a5_trial_count: got %0d distinct trials, need 8", trial_cnt);
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (trial_log[i] !== A5_SEQ[i]) begin
                    n_fail++; $display("FAIL a5_trial[%0d]: got %h, need %h", i, trial_log[i], A5_SEQ[i]);
                end
            end
        end
        tick();
        n_checks++;
        if (f_done !== 1'b0 || f_result !== 8'hA5) begin
            n_fail++; $display("FAIL a5_done_pulse: got done=%b result=%h, need 0 a5", f_done, f_result);
        end
    endtask

    task automatic test_extremes();
        int lat, busy_n;
        a_val = 8'h00;
        start_pulse();
        wait_done(1'b0, 1'b0, lat, busy_n);
        n_checks++;
        if (lat !== 16 || f_result !== 8'h00) begin
            n_fail++; $display("FAIL zero_conv: got lat=%0d result=%h, need 16 00", lat, f_result);
        end
        tick();
        a_val = 8'hFF;
        start_pulse();
        wait_done(1'b0, 1'b0, lat, busy_n);
        n_checks++;
        if (lat !== 16 || f_result !== 8'hFF || f_trial !== 8'hFF) begin
            n_fail++; $display("FAIL ff_conv: got lat=%0d result=%h trial=%h, need 16 ff ff", lat, f_result, f_trial);
        end
        tick(); tick();
        n_checks++;
        if (f_busy !== 1'b0 || f_done !== 1'b0 || f_result !== 8'hFF) begin
            n_fail++; $display("FAIL ff_no_wrap: got busy=%b done=%b result=%h, need 0 0 ff", f_busy, f_done, f_result);
        end
    endtask

    task automatic test_start_held();
        int lat, busy_n;
        a_val = 8'h3C;
        start_pulse();
        wait_done(1'b0, 1'b1, lat, busy_n);
        n_checks++;
        if (lat !== LAT_3C || busy_n !== LAT_3C || f_result !== 8'h3C) begin
            n_fail++;
            $display("FAIL held_start: got lat=%0d busy=%0d result=%h, need %0d %0d 3c", lat, busy_n, f_result, LAT_3C, LAT_3C);
        end
        tick();
        n_checks++;
        if (f_busy !== 1'b0 || f_done !== 1'b0 || f_result !== 8'h3C) begin
            n_fail++; $display("FAIL held_single: got busy=%b done=%b result=%h, need 0 0 3c", f_busy, f_done, f_result);
        end
    endtask

    task automatic test_back_to_back();
        int lat, busy_n;
        a_val = 8'h3C;
        start_pulse();
        wait_done(1'b0, 1'b0, lat, busy_n);
        a_val = 8'hC3;
        start_pulse();
        n_checks++;
        if (f_busy !== 1'b1 || f_done !== 1'b0 || f_trial !== 8'h80 || f_result !== 8'h3C) begin
            n_fail++;
            $display("FAIL b2b_restart: got busy=%b done=%b trial=%h result=%h, need 1 0 80 3c", f_busy, f_done, f_trial, f_result);
        end
        wait_done(1'b0, 1'b0, lat, busy_n);
        n_checks++;
        if (lat !== 16 || f_result !== 8'hC3) begin
            n_fail++; $display("FAIL b2b_second: got lat=%0d result=%h, need 16 c3", lat, f_result);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, busy_n;
        a_val = 8'h5A;
        start_pulse();
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (f_busy !== 1'b1 || f_result !== 8'hC3) begin
            n_fail++; $display("FAIL mid_hold: got busy=%b result=%h, need 1 c3", f_busy, f_result);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({f_trial, f_result, f_busy, f_done} !== 18'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got trial=%h result=%h busy=%b done=%b, need all 0", f_trial, f_result, f_busy, f_done);
        end
        tick();
        start_pulse();
        wait_done(1'b0, 1'b0, lat, busy_n);
        n_checks++;
        if (lat < 0 || f_result !== 8'h5A) begin
            n_fail++; $display("FAIL after_reset: got lat=%0d result=%h, need 5a", lat, f_result);
        end
        tick();
    endtask

    task automatic test_slow_settle();
        int lat, busy_n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_val = 8'h80;
        start_pulse();
        wait_done(1'b1, 1'b0, lat, busy_n);
        n_checks++;
        if (lat !== LAT_SLOW || busy_n !== LAT_SLOW) begin
            n_fail++; $display("FAIL slow_latency: got lat=%0d busy=%0d, need %0d", lat, busy_n, LAT_SLOW);
        end
        n_checks++;
        if (s_result !== 8'h80) begin
            n_fail++; $display("FAIL slow_result: got %h, need 80", s_result);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_start_held();
        test_back_to_back();
        test_reset_mid();
        test_slow_settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
